// File: rtl/top_level_dec.sv
// top_level_dec: fixed-latency modular exponentiation m = c^d_key mod n (RSA decryption).
//
// Right-to-left square-and-multiply over every bit of d_key, LSB first. Each exponent bit
// takes exactly WIDTH cycles. Two shift-add modular multipliers run side by side, one
// iteration per cycle:
//   P1 = result * base mod n
//   P2 = base   * base mod n
// Both scan base MSB first. Latency does not depend on the operand values.
//
// Ports:
//   clk    - clock; all state changes on the rising edge
//   reset  - asynchronous, active-low reset
//   start  - begin a decryption; sampled only in IDLE
//   c      - ciphertext      (WIDTH bits)
//   d_key  - private exponent (WIDTH bits)
//   n      - modulus         (WIDTH bits)
//   m      - recovered message; held from done until the next result
//   done   - one-cycle completion pulse
//   busy   - high from LOAD through the last CALC cycle
//   err    - invalid operands (n < 2 or c >= n); valid with done, cleared in LOAD
module top_level_dec #(
    parameter int unsigned WIDTH = 128
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d_key,
    input  logic [WIDTH-1:0] n,
    output logic [WIDTH-1:0] m,
    output logic             done,
    output logic             busy,
    output logic             err
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StLoad, StCalc, StFin} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] d_q, n_q;
    logic [WIDTH-1:0] result_q, base_q;
    logic [WIDTH-1:0] acc1_q, acc2_q;
    logic [CW-1:0]    bit_idx_q;   // exponent bit being processed
    logic [CW-1:0]    iter_q;      // multiplier scan position in base, MSB first
    logic [WIDTH-1:0] m_q;
    logic             done_q, busy_q, err_q;

    logic [WIDTH-1:0] dbl1, dbl2, p1_nxt, p2_nxt;
    logic             scan_bit, op_bad;

    // Single conditional subtraction. The input is always < 2n, so one subtraction
    // brings it back into [0, n).
    function automatic logic [WIDTH-1:0] mod_sub(input logic [WIDTH:0] x,
                                                 input logic [WIDTH-1:0] md);
        logic [WIDTH:0] diff;
        diff = x - {1'b0, md};
        return (x >= {1'b0, md}) ? diff[WIDTH-1:0] : x[WIDTH-1:0];
    endfunction

    always_comb begin
        scan_bit = base_q[iter_q];
        // The accumulators are < n, so the doubled value fits in WIDTH+1 bits.
        dbl1     = mod_sub({acc1_q, 1'b0}, n_q);
        dbl2     = mod_sub({acc2_q, 1'b0}, n_q);
        p1_nxt   = dbl1;
        p2_nxt   = dbl2;
        if (scan_bit) begin
            p1_nxt = mod_sub({1'b0, dbl1} + {1'b0, result_q}, n_q);
            p2_nxt = mod_sub({1'b0, dbl2} + {1'b0, base_q}, n_q);
        end
        op_bad = (n[WIDTH-1:1] == '0) || (c >= n);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            d_q       <= '0;
            n_q       <= '0;
            result_q  <= '0;
            base_q    <= '0;
            acc1_q    <= '0;
            acc2_q    <= '0;
            bit_idx_q <= '0;
            iter_q    <= '0;
            m_q       <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q <= StLoad;
                        busy_q  <= 1'b1;
                    end
                end
                StLoad: begin
                    d_q       <= d_key;
                    n_q       <= n;
                    result_q  <= WIDTH'(1);
                    base_q    <= c;
                    acc1_q    <= '0;
                    acc2_q    <= '0;
                    bit_idx_q <= '0;
                    iter_q    <= CW'(WIDTH - 1);
                    err_q     <= op_bad;
                    if (op_bad) begin
                        state_q <= StFin;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= StCalc;
                    end
                end
                StCalc: begin
                    if (iter_q == '0) begin
                        // Last scan step: the products are complete this cycle.
                        base_q <= p2_nxt;
                        if (d_q[bit_idx_q]) begin
                            result_q <= p1_nxt;
                        end
                        acc1_q    <= '0;
                        acc2_q    <= '0;
                        iter_q    <= CW'(WIDTH - 1);
                        bit_idx_q <= bit_idx_q + 1'b1;
                        if (bit_idx_q == CW'(WIDTH - 1)) begin
                            state_q <= StFin;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        acc1_q <= p1_nxt;
                        acc2_q <= p2_nxt;
                        iter_q <= iter_q - 1'b1;
                    end
                end
                StFin: begin
                    m_q     <= err_q ? '0 : result_q;
                    done_q  <= 1'b1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign m    = m_q;
    assign done = done_q;
    assign busy = busy_q;
    assign err  = err_q;

endmodule

// File: tb/tb_top_level_dec.sv
// Self-checking bench for top_level_dec, run at WIDTH=16 so that each job takes
// 16*16+2 = 258 edges.
module tb_top_level_dec;

    localparam int unsigned W   = 16;
    localparam int unsigned LAT = W * W + 2;

    logic         clk   = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] c     = '0;
    logic [W-1:0] d_key = '0;
    logic [W-1:0] n     = '0;
    logic [W-1:0] m;
    logic         done, busy, err;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    top_level_dec #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .c     (c),
        .d_key (d_key),
        .n     (n),
        .m     (m),
        .done  (done),
        .busy  (busy),
        .err   (err)
    );

    task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // Reference: plain square-and-multiply on integers.
    function automatic longint unsigned modexp(input longint unsigned b, input longint unsigned e,
                                               input longint unsigned md);
        longint unsigned r;
        r = 1;
        b = b % md;
        while (e != 0) begin
            if (e[0]) r = (r * b) % md;
            b = (b * b) % md;
            e = e >> 1;
        end
        return r % md;
    endfunction

    // Issue a job and wait (bounded) for done. lat counts rising edges after the
    // start-sampling edge up to the one that raises done.
    task automatic run_job(input string tag, input logic [W-1:0] cc, input logic [W-1:0] dd,
                           input logic [W-1:0] nn, input bit hold, input bit scramble,
                           output logic [W-1:0] got_m, output logic got_err, output int lat);
        @(negedge clk);
        reset = 1'b1;
        c     = cc;
        d_key = dd;
        n     = nn;
        start = 1'b1;
        @(posedge clk);
        #1;
        check({tag, " busy_after_start"}, busy, 1);
        lat = 0;
        while (lat < int'(LAT) + 20) begin
            @(posedge clk);
            lat++;
            #1;
            if (lat == 1 && !hold) start = 1'b0;
            if (lat == 1 && scramble) begin
                c     = W'($urandom);
                d_key = W'($urandom);
                n     = W'($urandom);
            end
            if (done) break;
        end
        check({tag, " done_seen"}, done, 1);
        check({tag, " busy_at_done"}, busy, 0);
        got_m   = m;
        got_err = err;
        @(posedge clk);
        #1;
        check({tag, " done_one_cycle"}, done, 0);
        if (hold) check({tag, " restart_after_fin"}, busy, 1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, " m"}, m, 0);
        check({tag, " done"}, done, 0);
        check({tag, " busy"}, busy, 0);
        check({tag, " err"}, err, 0);
    endtask

    initial begin
        logic [W-1:0] gm;
        logic         ge;
        int           lat;
        int           dcount;
        logic [W-1:0] rc, rd, rn;

        #1 reset = 1'b0;
        #1 check_outputs_zero("reset");

        // First start accepted on the first edge out of reset.
        run_job("rsa", 16'd948, 16'd157, 16'd2773, 1'b0, 1'b0, gm, ge, lat);
        check("rsa m", gm, 920);
        check("rsa err", ge, 0);
        check("rsa latency", lat, LAT);

        run_job("pow10", 16'd2, 16'd10, 16'd1000, 1'b0, 1'b0, gm, ge, lat);
        check("pow10 m", gm, 24);
        run_job("d1", 16'd777, 16'd1, 16'd1000, 1'b0, 1'b0, gm, ge, lat);
        check("d1 m", gm, 777);
        run_job("d0", 16'd777, 16'd0, 16'd1000, 1'b0, 1'b0, gm, ge, lat);
        check("d0 m", gm, 1);
        run_job("c0", 16'd0, 16'd55, 16'd1000, 1'b0, 1'b0, gm, ge, lat);
        check("c0 m", gm, 0);

        run_job("c_ge_n", 16'd3000, 16'd157, 16'd2773, 1'b0, 1'b0, gm, ge, lat);
        check("c_ge_n err", ge, 1);
        check("c_ge_n m", gm, 0);
        check("c_ge_n latency", lat, 2);
        run_job("n1", 16'd0, 16'd5, 16'd1, 1'b0, 1'b0, gm, ge, lat);
        check("n1 err", ge, 1);
        run_job("valid_after_err", 16'd948, 16'd157, 16'd2773, 1'b0, 1'b0, gm, ge, lat);
        check("valid_after_err err", ge, 0);
        check("valid_after_err m", gm, 920);

        // Abort mid-CALC: outputs clear at once, and no done follows.
        @(negedge clk);
        c = 16'd948; d_key = 16'd157; n = 16'd2773; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (100) @(posedge clk);
        #2 reset = 1'b0;
        #1 check_outputs_zero("abort");
        dcount = 0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (LAT + 10) begin
            @(posedge clk);
            #1;
            if (done) dcount++;
        end
        check("abort no_done", dcount, 0);
        run_job("restart", 16'd948, 16'd157, 16'd2773, 1'b0, 1'b0, gm, ge, lat);
        check("restart m", gm, 920);

        // start held high and operands scrambled after LOAD.
        run_job("hold", 16'd2, 16'd10, 16'd1000, 1'b1, 1'b1, gm, ge, lat);
        check("hold m", gm, 24);
        check("hold latency", lat, LAT);
        @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 12; i++) begin
            rn = W'($urandom_range(3, 65535)) | W'(1);
            rc = W'($urandom % rn);
            rd = W'($urandom);
            run_job("rand", rc, rd, rn, 1'b0, 1'b0, gm, ge, lat);
            check($sformatf("rand%0d m (c=%0d d=%0d n=%0d)", i, rc, rd, rn), gm,
                  modexp(rc, rd, rn));
            check($sformatf("rand%0d err", i), ge, 0);
            check($sformatf("rand%0d latency", i), lat, LAT);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/top_level_dec.md
TOP_LEVEL_DEC -- requirements
Module: top_level_dec

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 128, operand width in bits for ciphertext, key, modulus and message.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a decryption, sampled only in IDLE.
REQ-005 The block SHALL have port c, input, WIDTH bits: ciphertext.
REQ-006 The block SHALL have port d_key, input, WIDTH bits: private exponent.
REQ-007 The block SHALL have port n, input, WIDTH bits: modulus.
REQ-008 The block SHALL have port m, output, WIDTH bits: recovered message, m = c^d_key mod n.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-010 The block SHALL have port busy, output, 1 bit: high from LOAD through the last CALC cycle.
REQ-011 The block SHALL have port err, output, 1 bit: invalid operands flag, valid with done.

Function
REQ-012 The FSM SHALL have states IDLE, LOAD, CALC and FIN.
REQ-013 IDLE SHALL go to LOAD on the edge where start=1.
REQ-014 LOAD SHALL latch c, d_key and n; set result=1, base=c, bit index=0, iteration counter=WIDTH-1.
REQ-015 If n<2 or c>=n in LOAD, the FSM SHALL go directly to FIN with err=1 and m=0.
REQ-016 Otherwise, LOAD SHALL go to CALC.
REQ-017 CALC SHALL use right-to-left binary exponentiation over all WIDTH bits of d_key, LSB first, in fixed (constant-time) order.
REQ-018 Each exponent bit SHALL take exactly WIDTH cycles, running two interleaved shift-add modular multipliers in parallel: P1 = result*base mod n and P2 = base*base mod n.
REQ-019 Each multiplier iteration SHALL scan the multiplier operand MSB first: acc = 2*acc mod n, then if the operand bit is 1, acc = acc + a mod n.
REQ-020 Each reduction SHALL be a single conditional subtraction of n; intermediates SHALL be WIDTH+1 bits, with no overflow loss.
REQ-021 At the end of each exponent bit, base SHALL be set to P2; result SHALL be set to P1 when the d_key bit is 1, and left unchanged otherwise.
REQ-022 After bit WIDTH-1, CALC SHALL go to FIN.
REQ-023 FIN SHALL register m=result (or 0 on err), assert done=1 for exactly one cycle, and return to IDLE.
REQ-024 Latency SHALL be fixed: done high in the cycle beginning WIDTH*WIDTH+2 rising edges after the start-sampling edge (16386 for WIDTH=128), independent of operand values.
REQ-025 On the err path, done SHALL be high 2 edges after the start-sampling edge.
REQ-026 start SHALL be ignored while busy=1 and in FIN.
REQ-027 Input changes after LOAD SHALL NOT affect the result.
REQ-028 m and err SHALL hold their values from done until the next LOAD; LOAD SHALL clear err.
REQ-029 d_key=0 SHALL yield m=1 (n>=2); c=0 SHALL yield m=0 (d_key!=0).

Reset
REQ-030 reset=0 SHALL immediately force IDLE and set m=0, done=0, busy=0, err=0, and clear all internal registers, in any state, including mid-CALC.
REQ-031 The first start SHALL be accepted on the first rising edge with reset=1 and start=1.
REQ-032 A decryption aborted by reset SHALL produce no done pulse.

Verification
REQ-033 c=948, d_key=157, n=2773, WIDTH=128 -> done at edge 16386 after start, m=920, err=0.
REQ-034 c=2, d_key=10, n=1000 -> m=24; then d_key=1 with c=777 -> m=777; then d_key=0 -> m=1.
REQ-035 c=3000, n=2773 -> done 2 edges after start, err=1, m=0; then n=1 with c=0 -> err=1; a following valid job clears err.
REQ-036 reset pulled low mid-CALC at cycle 5000 -> outputs 0 immediately, no done; a restart with the REQ-033 operands -> m=920.
REQ-037 start held high throughout, with c/d_key/n changed during CALC -> single done, result from the latched operands, next job starts the edge after FIN.
REQ-038 Random c<n, d_key, odd n<2^128 -> m matches a reference model's modular exponentiation; latency constant across all cases.
